// File: rtl/ntt_pairwm_multilane.sv
// Multi-lane Karatsuba pairwise multiplier for the ML-KEM NTT domain.
// Five-stage stallable pipeline with accumulate, valid tracking and a per-polynomial beat counter.
module ntt_pairwm_multilane #(
    parameter int WIDTH     = 12,
    parameter int PRIME     = 3329,
    parameter int NUM_LANES = 2,
    parameter int NUM_PAIRS = 64,
    parameter int CNT_W     = $clog2(NUM_PAIRS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         zeroize,
    input  logic                         en_i,
    input  logic                         valid_i,
    input  logic                         accumulate_i,
    input  logic [NUM_LANES*2*WIDTH-1:0] u_i,
    input  logic [NUM_LANES*2*WIDTH-1:0] v_i,
    input  logic [NUM_LANES*2*WIDTH-1:0] w_i,
    input  logic [NUM_LANES*WIDTH-1:0]   zeta_i,
    output logic                         valid_o,
    output logic [NUM_LANES*2*WIDTH-1:0] uv_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             pair_cnt_o
);

    localparam int                PW   = 2 * WIDTH;
    localparam logic [WIDTH:0]    Q1   = (WIDTH + 1)'(PRIME);
    localparam logic [PW-1:0]     QP   = PW'(PRIME);
    // floor(2^PW / PRIME); with x < 2^PW the quotient estimate is short by at most one
    localparam logic [2*PW-1:0]   BM   = (2 * PW)'((64'd1 << PW) / 64'(PRIME));
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(NUM_PAIRS - 1);

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q1) begin
            s = s - Q1;
        end else begin
            s = s;
        end
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) begin
            d = d + Q1;
        end else begin
            d = d;
        end
        return WIDTH'(d);
    endfunction

    function automatic logic [PW-1:0] mul_w(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    endfunction

    function automatic logic [WIDTH-1:0] barrett(input logic [PW-1:0] x);
        logic [2*PW-1:0] prod;
        logic [PW-1:0]   qe;
        logic [PW-1:0]   r;
        prod = {{PW{1'b0}}, x} * BM;
        qe   = PW'(prod >> PW);
        r    = x - qe * QP;
        if (r >= QP) begin
            r = r - QP;
        end else begin
            r = r;
        end
        return WIDTH'(r);
    endfunction

    typedef struct packed {
        logic [PW-1:0]             p00;
        logic [PW-1:0]             p11;
        logic [PW-1:0]             pk;
        logic [WIDTH-1:0]          z1;
        logic [WIDTH-1:0]          z2;
        logic [WIDTH-1:0]          r00;
        logic [WIDTH-1:0]          r11;
        logic [WIDTH-1:0]          rk;
        logic [PW-1:0]             t;
        logic [WIDTH-1:0]          r00b;
        logic [WIDTH-1:0]          uv1a;
        logic [WIDTH-1:0]          uv0b;
        logic [WIDTH-1:0]          uv1b;
        logic [WIDTH-1:0]          uv0;
        logic [WIDTH-1:0]          uv1;
        logic [3:0][WIDTH-1:0]     w0;
        logic [3:0][WIDTH-1:0]     w1;
    } lane_t;

    logic [4:0]       vld_q, vld_d;
    logic [3:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Valid/accumulate shift chains and the output beat counter
    always_comb begin
        vld_d = vld_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (zeroize) begin
            vld_d = 5'b0;
            acc_d = 4'b0;
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
            vld_d = {vld_q[3:0], valid_i};
            acc_d = {acc_q[2:0], accumulate_i};
            if (vld_q[4]) begin
                cnt_d = (cnt_q == LAST) ? {CNT_W{1'b0}} : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            vld_d = vld_q;
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 5'b0;
            acc_q <= 4'b0;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            vld_q <= vld_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [WIDTH-1:0] u0_s, u1_s, v0_s, v1_s, z_s, w0_s, w1_s;
        lane_t            ln_q, ln_d;

        assign u0_s = u_i[(2*l)*WIDTH +: WIDTH];
        assign u1_s = u_i[(2*l+1)*WIDTH +: WIDTH];
        assign v0_s = v_i[(2*l)*WIDTH +: WIDTH];
        assign v1_s = v_i[(2*l+1)*WIDTH +: WIDTH];
        assign w0_s = w_i[(2*l)*WIDTH +: WIDTH];
        assign w1_s = w_i[(2*l+1)*WIDTH +: WIDTH];
        assign z_s  = zeta_i[l*WIDTH +: WIDTH];

        // Lane datapath: products, reductions, Karatsuba combine, zeta term, accumulate
        always_comb begin
            ln_d = ln_q;
            if (zeroize) begin
                ln_d = {$bits(lane_t){1'b0}};
            end else if (en_i) begin
                ln_d.p00  = mul_w(u0_s, v0_s);
                ln_d.p11  = mul_w(u1_s, v1_s);
                ln_d.pk   = mul_w(mod_add(u0_s, u1_s), mod_add(v0_s, v1_s));
                ln_d.z1   = z_s;
                ln_d.w0   = {ln_q.w0[2:0], w0_s};
                ln_d.w1   = {ln_q.w1[2:0], w1_s};
                ln_d.r00  = barrett(ln_q.p00);
                ln_d.r11  = barrett(ln_q.p11);
                ln_d.rk   = barrett(ln_q.pk);
                ln_d.z2   = ln_q.z1;
                ln_d.t    = mul_w(ln_q.r11, ln_q.z2);
                ln_d.r00b = ln_q.r00;
                ln_d.uv1a = mod_sub(mod_sub(ln_q.rk, ln_q.r00), ln_q.r11);
                ln_d.uv0b = mod_add(ln_q.r00b, barrett(ln_q.t));
                ln_d.uv1b = ln_q.uv1a;
                // w rides the same number of stages as the beat so latency is accumulate-independent
                ln_d.uv0  = acc_q[3] ? mod_add(ln_q.uv0b, ln_q.w0[3]) : ln_q.uv0b;
                ln_d.uv1  = acc_q[3] ? mod_add(ln_q.uv1b, ln_q.w1[3]) : ln_q.uv1b;
            end else begin
                ln_d = ln_q;
            end
        end

        // Lane pipeline registers
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                ln_q <= {$bits(lane_t){1'b0}};
            end else begin
                ln_q <= ln_d;
            end
        end

        assign uv_o[(2*l)*WIDTH +: WIDTH]   = ln_q.uv0;
        assign uv_o[(2*l+1)*WIDTH +: WIDTH] = ln_q.uv1;
    end

    assign valid_o    = vld_q[4];
    assign pair_cnt_o = cnt_q;
    // Held-over done reappears once the stall lifts because the counter is frozen too
    assign done_o     = vld_q[4] & en_i & (cnt_q == LAST);

endmodule

// File: tb/tb_ntt_pairwm_multilane.sv
// Directed bench for ntt_pairwm_multilane: arithmetic, accumulate, stall, counter/done,
// zeroize/reset clearing, plus a short randomised run against a plain modular model.
module tb_ntt_pairwm_multilane;

    localparam int W  = 12;
    localparam int Q  = 3329;
    localparam int L  = 2;
    localparam int NP = 64;

    logic              clk;
    logic              reset_n;
    logic              zeroize;
    logic              en_i;
    logic              valid_i;
    logic              accumulate_i;
    logic [L*2*W-1:0]  u_i;
    logic [L*2*W-1:0]  v_i;
    logic [L*2*W-1:0]  w_i;
    logic [L*W-1:0]    zeta_i;
    logic              valid_o;
    logic [L*2*W-1:0]  uv_o;
    logic              done_o;
    logic [5:0]        pair_cnt_o;

    int n_cmp;
    int n_err;
    int sent;
    int got;
    int k;
    int dones;
    bit e_s;
    bit v_s;
    logic [47:0] exp_q[$];
    logic [47:0] ex;
    logic [23:0] r0;
    logic [23:0] r1;
    int ru[8];

    ntt_pairwm_multilane #(
        .WIDTH(W), .PRIME(Q), .NUM_LANES(L), .NUM_PAIRS(NP), .CNT_W(6)
    ) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .en_i(en_i),
        .valid_i(valid_i), .accumulate_i(accumulate_i), .u_i(u_i), .v_i(v_i),
        .w_i(w_i), .zeta_i(zeta_i), .valid_o(valid_o), .uv_o(uv_o),
        .done_o(done_o), .pair_cnt_o(pair_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int u0, input int u1, input int v0, input int v1,
                            input int z, input int w0, input int w1);
        u_i[(2*l)*W +: W]   = W'(u0);
        u_i[(2*l+1)*W +: W] = W'(u1);
        v_i[(2*l)*W +: W]   = W'(v0);
        v_i[(2*l+1)*W +: W] = W'(v1);
        w_i[(2*l)*W +: W]   = W'(w0);
        w_i[(2*l+1)*W +: W] = W'(w1);
        zeta_i[l*W +: W]    = W'(z);
    endtask

    function automatic logic [63:0] pk(input int a0, input int b0, input int a1, input int b1);
        return {16'd0, W'(b1), W'(a1), W'(b0), W'(a0)};
    endfunction

    // Schoolbook reference: uv1 = u0*v1 + u1*v0, independent of the Karatsuba form
    function automatic logic [23:0] ref_lane(input longint u0, input longint u1, input longint v0,
                                             input longint v1, input longint z, input longint w0,
                                             input longint w1, input bit acc);
        longint a;
        longint b;
        a = (u0 * v0 + ((u1 * v1) % Q) * z) % Q;
        b = (u0 * v1 + u1 * v0) % Q;
        if (acc) begin
            a = (a + w0) % Q;
            b = (b + w1) % Q;
        end
        return {W'(b), W'(a)};
    endfunction

    task automatic basic_data();
        set_lane(0, 1, 2, 3, 4, 17, 3328, 5);
        set_lane(1, 3328, 3328, 3328, 3328, 1, 1, 1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset_n = 1'b0; zeroize = 1'b0; en_i = 1'b0; valid_i = 1'b0; accumulate_i = 1'b0;
        u_i = '0; v_i = '0; w_i = '0; zeta_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_val("rst_valid", 64'(valid_o), 64'd0);
        check_val("rst_uv", 64'(uv_o), 64'd0);
        check_val("rst_cnt", 64'(pair_cnt_o), 64'd0);
        check_val("rst_done", 64'(done_o), 64'd0);

        // Basic Karatsuba, 5-cycle latency
        en_i = 1'b1; valid_i = 1'b1; accumulate_i = 1'b0;
        basic_data();
        step();
        valid_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check_val("lat_idle", 64'(valid_o), 64'd0);
        end
        step();
        check_val("basic_valid", 64'(valid_o), 64'd1);
        check_val("basic_uv", 64'(uv_o), pk(139, 10, 2, 2));
        step();
        check_val("basic_drop", 64'(valid_o), 64'd0);

        // Accumulate beat followed by plain beat with the same w
        valid_i = 1'b1; accumulate_i = 1'b1;
        step();
        accumulate_i = 1'b0;
        step();
        valid_i = 1'b0;
        step(); step();
        check_val("acc_lat", 64'(valid_o), 64'd0);
        step();
        check_val("acc_valid", 64'(valid_o), 64'd1);
        check_val("acc_uv", 64'(uv_o), pk(138, 15, 3, 3));
        step();
        check_val("noacc_valid", 64'(valid_o), 64'd1);
        check_val("noacc_uv", 64'(uv_o), pk(139, 10, 2, 2));

        // Back-to-back 8 beats with a 3-cycle stall mid-stream
        zeroize = 1'b1; step(); zeroize = 1'b0;
        sent = 0; got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            e_s = !(c >= 6 && c <= 8);
            v_s = 1'b1;
            en_i = e_s;
            valid_i = v_s && (sent < 8 || !e_s);
            if (e_s && sent < 8) begin
                set_lane(0, sent, 1, 2, 3, 1, 7, 7);
                set_lane(1, 1, sent, 1, 1, 5, 7, 7);
            end else begin
                set_lane(0, 100, 200, 300, 400, 9, 1, 1);
                set_lane(1, 500, 600, 700, 800, 9, 1, 1);
            end
            step();
            if (e_s && valid_i) sent++;
            if (!e_s) begin
                check_val("stall_valid", 64'(valid_o), 64'd1);
                check_val("stall_uv", 64'(uv_o), pk(2*(got-1)+3, 3*(got-1)+2, 1+5*(got-1), got));
                check_val("stall_done", 64'(done_o), 64'd0);
            end else if (valid_o) begin
                check_val("b2b_uv", 64'(uv_o), pk(2*got+3, 3*got+2, 1+5*got, 1+got));
                if (got == 7) check_val("b2b_span", 64'(c), 64'd14);
                got++;
            end
        end
        en_i = 1'b1; valid_i = 1'b0;
        check_val("b2b_count", 64'(got), 64'd8);

        // Counter and done over 65 output beats
        zeroize = 1'b1; step(); zeroize = 1'b0;
        check_val("zc_cnt", 64'(pair_cnt_o), 64'd0);
        basic_data();
        sent = 0; k = 0; dones = 0;
        for (int c = 0; c < 100 && k < 65; c++) begin
            valid_i = (sent < 65);
            step();
            if (valid_i) sent++;
            if (valid_o) begin
                check_val("cnt_val", 64'(pair_cnt_o), (k == 64) ? 64'd0 : 64'(k));
                check_val("cnt_done", 64'(done_o), (k == 63) ? 64'd1 : 64'd0);
                if (done_o) dones++;
                if (k == 63) begin
                    en_i = 1'b0; #1;
                    check_val("done_stall", 64'(done_o), 64'd0);
                    en_i = 1'b1; #1;
                    check_val("done_resume", 64'(done_o), 64'd1);
                end
                k++;
            end
        end
        valid_i = 1'b0;
        step();
        check_val("cnt_after65", 64'(pair_cnt_o), 64'd1);
        check_val("done_after65", 64'(done_o), 64'd0);
        check_val("done_pulses", 64'(dones), 64'd1);
        check_val("cnt_beats", 64'(k), 64'd65);

        // Zeroize with beats in flight; a beat offered on the zeroize edge is dropped too
        valid_i = 1'b1;
        step(); step(); step();
        zeroize = 1'b1;
        step();
        zeroize = 1'b0; valid_i = 1'b0;
        check_val("zero_valid", 64'(valid_o), 64'd0);
        check_val("zero_cnt", 64'(pair_cnt_o), 64'd0);
        check_val("zero_uv", 64'(uv_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("zero_flush", 64'(valid_o), 64'd0);
        end
        check_val("zero_cnt_hold", 64'(pair_cnt_o), 64'd0);

        // Asynchronous reset between edges with data in flight
        valid_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        valid_i = 1'b0;
        check_val("prerst_valid", 64'(valid_o), 64'd1);
        check_val("prerst_cnt", 64'(pair_cnt_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_valid", 64'(valid_o), 64'd0);
        check_val("arst_uv", 64'(uv_o), 64'd0);
        check_val("arst_cnt", 64'(pair_cnt_o), 64'd0);
        check_val("arst_done", 64'(done_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("arst_flush", 64'(valid_o), 64'd0);
        end

        // Random regression against the schoolbook model
        for (int c = 0; c < 400; c++) begin
            e_s = ($urandom_range(0, 3) != 0);
            v_s = ($urandom_range(0, 9) < 7);
            en_i = e_s; valid_i = v_s;
            accumulate_i = $urandom_range(0, 1);
            for (int j = 0; j < 8; j++) ru[j] = $urandom_range(0, Q - 1);
            set_lane(0, ru[0], ru[1], ru[2], ru[3], ru[4], ru[5], ru[6]);
            r0 = ref_lane(ru[0], ru[1], ru[2], ru[3], ru[4], ru[5], ru[6], accumulate_i);
            for (int j = 0; j < 8; j++) ru[j] = $urandom_range(0, Q - 1);
            set_lane(1, ru[0], ru[1], ru[2], ru[3], ru[4], ru[5], ru[6]);
            r1 = ref_lane(ru[0], ru[1], ru[2], ru[3], ru[4], ru[5], ru[6], accumulate_i);
            if (e_s && v_s) exp_q.push_back({r1, r0});
            step();
            if (e_s && valid_o) begin
                if (exp_q.size() == 0) begin
                    check_val("rnd_extra", 64'd1, 64'd0);
                end else begin
                    ex = exp_q.pop_front();
                    check_val("rnd_uv", 64'(uv_o), 64'(ex));
                end
            end
        end
        en_i = 1'b1; valid_i = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step();
            if (valid_o) begin
                ex = exp_q.pop_front();
                check_val("rnd_drain", 64'(uv_o), 64'(ex));
            end
        end
        check_val("rnd_left", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
